uart_tx: RTL and testbench

//   UART transmitter: the upstream stage feeding the UART receiver's RX_IN.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_if.sv | 32 +++
 rtl/uart_tx_parity_calc.sv | 21 ++
 rtl/uart_tx.sv | 178 +++++++++++++++++
 tb/tb_uart_tx.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// UART shared types and line-level constants.
// Used by the transmitter, the receiver and their benches.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic EVEN      = 1'b0;
  localparam logic ODD       = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// UART transmitter request/line bundle.
// master drives the byte request; slave is the transmitter.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  Busy
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output Busy
  );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// UART transmitter parity bit generator.
// Purely combinational over the latched frame data.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // even parity repeats the data xor; odd inverts it
  always_comb begin
    par_bit = ^data;
    if (par_typ == ODD) begin
      par_bit = ~^data;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, stop.
// UART_TX_HOLD_REG_EN adds a one-entry hold register for gapless frames.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic                  load;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_pen;
  logic                  ld_typ;
  logic                  par_bit;

`ifdef UART_TX_HOLD_REG_EN
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_pen_q, hold_pen_d;
  logic                  hold_typ_q, hold_typ_d;
  logic                  frame_free;
`endif

  assign accept     = bus.Data_Valid & ~busy_q;
  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_par (
    .data   (data_q),
    .par_typ(par_typ_q),
    .par_bit(par_bit)
  );

  // pick the source of the next frame and manage the hold slot
  always_comb begin
    load    = 1'b0;
    ld_data = bus.P_DATA;
    ld_pen  = bus.PAR_EN;
    ld_typ  = bus.PAR_TYP;
`ifdef UART_TX_HOLD_REG_EN
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_pen_d  = hold_pen_q;
    hold_typ_d  = hold_typ_q;
    frame_free  = (state_q == IDLE) || (state_q == STOP);
    if (frame_free && hold_full_q) begin
      load        = 1'b1;
      ld_data     = hold_data_q;
      ld_pen      = hold_pen_q;
      ld_typ      = hold_typ_q;
      hold_full_d = 1'b0;
    end else if (frame_free && accept) begin
      load = 1'b1;
    end
    if (accept && !(frame_free && !hold_full_q)) begin
      hold_full_d = 1'b1;
      hold_data_d = bus.P_DATA;
      hold_pen_d  = bus.PAR_EN;
      hold_typ_d  = bus.PAR_TYP;
    end
`else
    load = accept && (state_q == IDLE);
`endif
  end

  // frame sequencing, bit counter and shift register
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    unique case (state_q)
      IDLE:    state_d = IDLE;
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == LAST) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          shift_d = shift_q >> 1;
        end
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d   = START;
      cnt_d     = '0;
      shift_d   = ld_data;
      data_d    = ld_data;
      par_en_d  = ld_pen;
      par_typ_d = ld_typ;
    end
  end

  // line level and busy for the cycle after the edge
  always_comb begin
    tx_d = STOP_BIT;
    unique case (state_d)
      IDLE:    tx_d = STOP_BIT;
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit;
      STOP:    tx_d = STOP_BIT;
      default: tx_d = STOP_BIT;
    endcase
`ifdef UART_TX_HOLD_REG_EN
    busy_d = hold_full_d;
`else
    busy_d = (state_d != IDLE);
`endif
  end

  // frame state registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= STOP_BIT;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

`ifdef UART_TX_HOLD_REG_EN
  // hold slot registers; reset empties the slot
  always_ff @(posedge CLK) begin
    if (!RST) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_pen_q  <= 1'b0;
      hold_typ_q  <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_pen_q  <= hold_pen_d;
      hold_typ_q  <= hold_typ_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame tables, corner sequences,
// and random traffic against a queue-based line model.
module tb_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_tx_if #(.DATA_WIDTH(8)) bus ();

  uart_tx #(
    .DATA_WIDTH(8)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef bit bq_t[$];

  // model: bits still to appear on the line, plus an optional queued frame
  bq_t cur;
  bq_t hold;
  bit  m_busy = 1'b0;
  int  acc_cnt = 0;
  bit  chk_en = 1'b0;

`ifdef UART_TX_HOLD_REG_EN
  localparam bit RUN_BUSY = 1'b0;
`else
  localparam bit RUN_BUSY = 1'b1;
`endif

  typedef struct {
    logic [7:0] d;
    bit         pen;
    bit         pt;
    string      bits;
  } vec_t;

  function automatic bq_t mk_frame(logic [7:0] d, logic pen, logic pt);
    bq_t f;
    int ones;
    ones = 0;
    f.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      f.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) begin
      if (pt) f.push_back(ones % 2 == 0);
      else    f.push_back(ones % 2 == 1);
    end
    f.push_back(1'b1);
    return f;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b, expected %b, t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc;
    if (!rst_n) begin
      cur.delete();
      hold.delete();
      m_busy = 1'b0;
      return;
    end
    acc = bus.Data_Valid && !m_busy;
    if (cur.size() != 0) void'(cur.pop_front());
`ifdef UART_TX_HOLD_REG_EN
    if (cur.size() == 0 && hold.size() != 0) begin
      cur = hold;
      hold.delete();
    end
    if (acc) begin
      if (cur.size() == 0) cur = mk_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
      else hold = mk_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
    end
    m_busy = (hold.size() != 0);
`else
    if (acc) cur = mk_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
    m_busy = (cur.size() != 0);
`endif
    if (acc) acc_cnt++;
  endtask

  // advance the model on every rising edge
  initial forever begin
    @(posedge clk);
    model_step();
  end

  // compare line and busy against the model mid-cycle
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_tx", bus.TX_OUT, (cur.size() != 0) ? cur[0] : 1'b1);
      check("model_busy", bus.Busy, m_busy);
    end
  end

  task automatic drive(input bit dv, input logic [7:0] d, input bit pen, input bit pt);
    bus.Data_Valid = dv;
    bus.P_DATA     = d;
    bus.PAR_EN     = pen;
    bus.PAR_TYP    = pt;
  endtask

  // send one frame from idle and compare it with a literal bit string
  task automatic run_frame(input logic [7:0] d, input bit pen, input bit pt,
                           input string exp, input string name);
    drive(1'b1, d, pen, pt);
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < exp.len(); i++) begin
      check(name, bus.TX_OUT, exp[i] == "1");
      check({name, "_busy"}, bus.Busy, RUN_BUSY);
      @(negedge clk);
    end
    check({name, "_idle"}, bus.TX_OUT, 1'b1);
    check({name, "_idle_busy"}, bus.Busy, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    vec_t  tbl[7];
    string exp;
    int    base;

    tbl[0] = '{8'hB2, 1'b0, 1'b0, "0010011011"};
    tbl[1] = '{8'hB2, 1'b1, 1'b0, "00100110101"};
    tbl[2] = '{8'hB2, 1'b1, 1'b1, "00100110111"};
    tbl[3] = '{8'hA4, 1'b1, 1'b0, "00010010111"};
    tbl[4] = '{8'h00, 1'b1, 1'b1, "00000000011"};
    tbl[5] = '{8'hFF, 1'b1, 1'b0, "01111111101"};
    tbl[6] = '{8'hFF, 1'b0, 1'b1, "0111111111"};

    // reset held over two edges with a request pending
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_tx", bus.TX_OUT, 1'b1);
    check("rst_busy", bus.Busy, 1'b0);
    bus.Data_Valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_tx", bus.TX_OUT, 1'b1);
      check("post_rst_busy", bus.Busy, 1'b0);
    end

    // table of single frames
    for (int t = 0; t < 7; t++) begin
      run_frame(tbl[t].d, tbl[t].pen, tbl[t].pt, tbl[t].bits, $sformatf("tbl%0d", t));
    end

    // back-to-back request with Data_Valid held high
`ifdef UART_TX_HOLD_REG_EN
    exp = {"0010011011", "00010010111", "1111"};
`else
    exp = {"0010011011", "1", "00010010111", "1111"};
`endif
    base = acc_cnt;
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'hA4, 1'b1, 1'b0);
    for (int i = 0; i < exp.len(); i++) begin
      check("b2b", bus.TX_OUT, exp[i] == "1");
      if (acc_cnt >= base + 2) bus.Data_Valid = 1'b0;
      @(negedge clk);
    end
    if (acc_cnt != base + 2) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL b2b_accepts: got %0d, expected 2", acc_cnt - base);
    end
    bus.Data_Valid = 1'b0;
    repeat (2) @(negedge clk);

`ifndef UART_TX_HOLD_REG_EN
    // request during DATA is dropped
    exp = {"0010011011", "1111"};
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < exp.len(); i++) begin
      check("drop", bus.TX_OUT, exp[i] == "1");
      if (i == 3) drive(1'b1, 8'h55, 1'b1, 1'b1);
      else bus.Data_Valid = 1'b0;
      @(negedge clk);
    end
`endif

    // reset during DATA bit 3, then a clean frame
    exp = "00100";
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    @(negedge clk);
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("mid_rst_pre", bus.TX_OUT, exp[i] == "1");
      if (i == 4) rst_n = 1'b0;
      @(negedge clk);
    end
    check("mid_rst_tx", bus.TX_OUT, 1'b1);
    check("mid_rst_busy", bus.Busy, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_idle", bus.TX_OUT, 1'b1);
    end
    run_frame(8'hA4, 1'b0, 1'b0, "0001001011", "after_rst");

    // random traffic with sparse resets
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom),
            1'($urandom));
      @(negedge clk);
    end
    rst_n = 1'b1;
    bus.Data_Valid = 1'b0;
    repeat (30) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
